// File: rtl/bitty_pkg.sv
// bitty_pkg: loader state encoding and instruction memory geometry shared with the fetch unit
package bitty_pkg;
  localparam int IMEM_DEPTH = 256;
  localparam int INSTR_W = 16;
  typedef enum logic [2:0] {IDLE, LEN, HI, LO, WRITE, DONE} loader_state_e;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream handshake plus instruction memory write port
interface imem_loader_if
  import bitty_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = INSTR_W
);
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  modport master (input rx_data, rx_valid, output rx_ready, mem_we, mem_addr, mem_wdata);
  modport slave (output rx_data, rx_valid, input rx_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_loader_timeout_counter.sv
// loader_timeout_counter: counts enabled idle cycles and flags when LIMIT-1 is reached; LIMIT=0 never expires
module loader_timeout_counter #(
  parameter int LIMIT = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CW = LIMIT > 1 ? $clog2(LIMIT) : 1;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    expire = (LIMIT != 0) && enable && count_q == CW'(LIMIT - 1);
    count_d = clear ? '0 : (enable && !expire) ? count_q + 1'b1 : count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else count_q <= count_d;
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: assembles a length-prefixed big-endian byte stream into sequential instruction memory writes
module imem_loader
  import bitty_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = INSTR_W,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  imem_loader_if.master bus,
  output logic core_hold,
  output logic busy,
  output logic done,
  output logic error,
  output logic [ADDR_W:0] words_loaded
);
  loader_state_e state_q, state_d;
  logic [ADDR_W:0] rem_q, rem_d, words_q, words_d;
  logic [ADDR_W-1:0] addr_q, addr_d, maddr_q, maddr_d;
  logic [7:0] hi_q, hi_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic we_q, we_d, err_q, err_d;
  logic go, accept, expire, timeout, last;
  assign go = state_q == IDLE && start;
  assign accept = bus.rx_valid && bus.rx_ready;
  assign timeout = expire && !accept;
  assign last = rem_q == (ADDR_W+1)'(1);
  loader_timeout_counter #(.LIMIT(TIMEOUT_CYC)) u_timeout (
    .clk(clk),
    .rst(reset),
    .clear(go || accept),
    .enable(bus.rx_ready),
    .expire(expire)
  );
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = start ? LEN : IDLE;
      LEN: state_d = accept ? HI : timeout ? IDLE : LEN;
      HI: state_d = accept ? LO : timeout ? IDLE : HI;
      LO: state_d = accept ? WRITE : timeout ? IDLE : LO;
      WRITE: state_d = last ? DONE : HI;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.rx_ready = state_q inside {LEN, HI, LO};
    busy = state_q != IDLE;
    core_hold = state_q != IDLE;
    done = state_q == DONE;
  end
  // the final increment is skipped so a 256-word session leaves the address at the top word
  always_comb begin
    rem_d = (state_q == LEN && accept) ? (ADDR_W+1)'(bus.rx_data == 8'd0 ? 9'd256 : {1'b0, bus.rx_data})
          : state_q == WRITE ? rem_q - 1'b1 : rem_q;
    addr_d = (state_q == LEN && accept) ? '0 : (state_q == WRITE && !last) ? addr_q + 1'b1 : addr_q;
    hi_d = (state_q == HI && accept) ? bus.rx_data : hi_q;
    we_d = state_q == LO && accept;
    wdata_d = we_d ? DATA_W'({hi_q, bus.rx_data}) : wdata_q;
    maddr_d = we_d ? addr_q : maddr_q;
    words_d = go ? '0 : state_q == WRITE ? words_q + 1'b1 : words_q;
    err_d = go ? 1'b0 : timeout ? 1'b1 : err_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      addr_q <= '0;
      hi_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      maddr_q <= '0;
      words_q <= '0;
      err_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      addr_q <= addr_d;
      hi_q <= hi_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
      maddr_q <= maddr_d;
      words_q <= words_d;
      err_q <= err_d;
    end
  end
  assign bus.mem_we = we_q;
  assign bus.mem_addr = maddr_q;
  assign bus.mem_wdata = wdata_q;
  assign error = err_q;
  assign words_loaded = words_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: load sessions checked against a stream-level model of the expected memory writes
module tb_imem_loader;
  typedef logic [7:0] bq_t[$];
  typedef struct packed {logic [7:0] a; logic [15:0] d;} wr_t;
  typedef struct {logic [7:0] n; int pat; int gap; int exp_words; int exp_last;} vec_t;

  logic clk = 0, reset = 1, start = 0;
  logic core_hold, busy, done, error;
  logic [8:0] words_loaded;
  int passed = 0, total = 0;
  int done_cnt = 0, late_busy = 0;
  logic prev_done = 0;
  wr_t wq[$];

  imem_loader_if #(.ADDR_W(8), .DATA_W(16)) bus ();
  imem_loader #(.ADDR_W(8), .DATA_W(16), .TIMEOUT_CYC(50)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .core_hold(core_hold), .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_we) wq.push_back({bus.mem_addr, bus.mem_wdata});
    if (done) done_cnt++;
    if (prev_done && busy) late_busy++;
    prev_done = done;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic idle(input int k);
    bus.rx_valid = 0;
    repeat (k) @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.rx_valid = 0;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  // leaves rx_valid high so back-to-back calls model a continuous stream
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.rx_data = b;
    bus.rx_valid = 1;
    while (!bus.rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("rx_ready_wait", 0, 1);
    @(negedge clk);
  endtask

  function automatic bq_t mk(input logic [7:0] n, input int pat);
    bq_t q;
    int cnt = (n == 0) ? 256 : int'(n);
    q.push_back(n);
    for (int i = 0; i < 2 * cnt; i++) q.push_back(pat == 1 ? 8'(i) : 8'($urandom));
    return q;
  endfunction

  task automatic load(input bq_t s, input int gap, input bit glitch);
    int n, k, bad;
    n = (s[0] == 0) ? 256 : int'(s[0]);
    wq.delete();
    done_cnt = 0;
    late_busy = 0;
    pulse_start();
    check("start_busy", busy, 1);
    check("start_hold", core_hold, 1);
    check("start_error", error, 0);
    check("start_words", words_loaded, 0);
    foreach (s[i]) begin
      if (glitch && i == 1) begin
        bus.rx_valid = 0;
        start = 1;
        @(negedge clk);
        start = 0;
      end
      if (gap > 0) idle($urandom_range(0, gap));
      send_byte(s[i]);
    end
    bus.rx_valid = 0;
    k = 0;
    while (busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("session_end", busy, 0);
    check("write_count", wq.size(), n);
    bad = 0;
    foreach (wq[i]) begin
      if (2 * i + 2 < s.size() && (int'(wq[i].a) != i || wq[i].d != {s[2*i+1], s[2*i+2]})) begin
        if (bad == 0) $display("FAIL write_entry %0d: got %h@%h expected %h%h@%h", i, wq[i].d, wq[i].a, s[2*i+1], s[2*i+2], 8'(i));
        bad++;
      end
    end
    check("write_data", bad, 0);
    check("done_pulses", done_cnt, 1);
    check("busy_after_done", late_busy, 0);
    check("words_loaded", words_loaded, n);
    check("end_error", error, 0);
    check("end_hold", core_hold, 0);
  endtask

  initial begin
    vec_t tbl[5];
    bq_t s;
    int k;
    tbl = '{'{8'd1, 0, 0, 1, 0}, '{8'd3, 0, 3, 3, 2}, '{8'd7, 0, 2, 7, 6},
            '{8'd0, 1, 0, 256, 255}, '{8'd255, 0, 1, 255, 254}};
    bus.rx_valid = 0;
    bus.rx_data = 0;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.rx_ready, 0);
    check("rst_we", bus.mem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_hold", core_hold, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_words", words_loaded, 0);
    reset = 0;
    @(negedge clk);

    // basic two-word stream with rx_valid held high throughout, cycle-exact latency
    wq.delete();
    done_cnt = 0;
    pulse_start();
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
    bus.rx_valid = 0;
    check("t1_we", bus.mem_we, 1);
    check("t1_addr", bus.mem_addr, 1);
    check("t1_wdata", bus.mem_wdata, 16'hABCD);
    @(negedge clk);
    check("t1_done", done, 1);
    check("t1_we_off", bus.mem_we, 0);
    check("t1_busy_in_done", busy, 1);
    check("t1_words", words_loaded, 2);
    @(negedge clk);
    check("t1_busy_off", busy, 0);
    check("t1_done_off", done, 0);
    check("t1_hold_off", core_hold, 0);
    @(negedge clk);
    check("t1_we_cycles", wq.size(), 2);
    if (wq.size() == 2) begin
      check("t1_w0", {wq[0].a, wq[0].d}, 24'h001234);
      check("t1_w1", {wq[1].a, wq[1].d}, 24'h01ABCD);
    end
    check("t1_done_cnt", done_cnt, 1);

    for (int i = 0; i < 5; i++) begin
      load(mk(tbl[i].n, tbl[i].pat), tbl[i].gap, 0);
      check("tbl_words", words_loaded, tbl[i].exp_words);
      check("tbl_last_addr", wq.size() > 0 ? int'(wq[$].a) : -1, tbl[i].exp_last);
    end

    for (int i = 0; i < 6; i++) begin
      s = mk(8'($urandom_range(1, 6)), 0);
      load(s, 0, 0);
      load(s, 5, 0);
    end

    // timeout after a half-assembled word
    wq.delete();
    done_cnt = 0;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'hAA);
    bus.rx_valid = 0;
    k = 0;
    while (!error && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("to_cycles", k, 50);
    check("to_busy", busy, 0);
    check("to_hold", core_hold, 0);
    check("to_writes", wq.size(), 0);
    check("to_done", done_cnt, 0);
    check("to_words", words_loaded, 0);
    repeat (3) @(negedge clk);
    check("to_sticky", error, 1);
    load(mk(8'd4, 0), 2, 0);

    // reset while waiting for a low byte with rx_valid high
    wq.delete();
    pulse_start();
    send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    reset = 1;
    bus.rx_data = 8'h44;
    bus.rx_valid = 1;
    @(negedge clk);
    check("rr_we", bus.mem_we, 0);
    check("rr_ready", bus.rx_ready, 0);
    check("rr_busy", busy, 0);
    check("rr_done", done, 0);
    check("rr_error", error, 0);
    check("rr_hold", core_hold, 0);
    check("rr_addr", bus.mem_addr, 0);
    check("rr_wdata", bus.mem_wdata, 0);
    check("rr_words", words_loaded, 0);
    reset = 0;
    repeat (5) @(negedge clk);
    check("rr_no_session", busy, 0);
    check("rr_no_ready", bus.rx_ready, 0);
    check("rr_writes", wq.size(), 1);
    bus.rx_valid = 0;

    // start pulse while a session is waiting for a high byte
    load(mk(8'd2, 0), 0, 1);
    load(mk(8'd5, 0), 3, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
